// File: rtl/npu_pkg.sv
// Shared definitions for the parametrised NPU core: FSM state codes,
// activation mode codes and the clamp helper used by the activation stage.
package npu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_MAC   = 4'd1,
    ST_ACT   = 4'd2,
    ST_WRITE = 4'd3,
    ST_DONE  = 4'd4
  } state_t;

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_RELU = 2'b01;
  localparam logic [1:0] MODE_SAT  = 2'b10;

  // Clamp v into the signed dw-bit range; floor_zero raises the lower bound to 0.
  // Works on 64-bit values, so the caller's pre-activation width must be <= 64.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int dw,
                                                  input logic floor_zero);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = floor_zero ? 64'sd0 : -(64'sd1 <<< (dw - 1));
    if (v > hi)
      saturate = hi;
    else if (v < lo)
      saturate = lo;
    else
      saturate = v;
  endfunction

endpackage

// File: rtl/npu_out_fifo.sv
// Result FIFO: RAM-backed queue with a registered read port and a one-cycle
// valid pulse per pop. A full FIFO still accepts a push when a pop happens alongside.
module npu_out_fifo #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          rd_en,
  output logic          push_ready,
  output logic [DW-1:0] d_out,
  output logic          d_valid,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [DW-1:0] d_out_reg;
  logic          d_valid_reg;
  logic          pop;
  logic          do_push;

  assign full       = (count_reg == CW'(FIFO_DEPTH));
  assign empty      = (count_reg == '0);
  assign pop        = rd_en && !empty;
  assign push_ready = !full || pop;
  assign do_push    = push && push_ready;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      d_out_reg   <= '0;
      d_valid_reg <= 1'b0;
    end else begin
      d_valid_reg <= pop;
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        d_out_reg  <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (do_push && !pop)
        count_reg <= count_reg + CW'(1);
      else if (pop && !do_push)
        count_reg <= count_reg - CW'(1);
    end
  end

  assign d_out   = d_out_reg;
  assign d_valid = d_valid_reg;
  assign count   = count_reg;

endmodule

// File: rtl/npu_core_param.sv
// Parametrised NPU core: serial signed dot product over NCH channels, bias,
// arithmetic shift and selectable activation, results queued in npu_out_fifo.
module npu_core_param
  import npu_pkg::*;
#(
  parameter int DW         = 8,
  parameter int NCH        = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int ACC_W     = 2 * DW + $clog2(NCH) + 1,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              CLKEXT,
  input  logic              RST_GLO,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [3:0]        SHIFT,
  input  logic [NCH*DW-1:0] D_IN,
  input  logic [NCH*DW-1:0] W_IN,
  input  logic [DW-1:0]     BIAS_IN,
  input  logic              RD_EN,
  output logic [DW-1:0]     D_OUT,
  output logic              D_VALID,
  output logic              FIFO_FULL,
  output logic              FIFO_EMPTY,
  output logic [CW-1:0]     FIFO_COUNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF,
  output logic [3:0]        STATE_DEBUG
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

  state_t                   state_reg, state_next;
  logic [NCH*DW-1:0]        d_reg, w_reg;
  logic signed [DW-1:0]     bias_reg;
  logic [1:0]               mode_reg;
  logic [3:0]               shift_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [CH_W-1:0]          ch_reg;
  logic [DW-1:0]            result_reg;
  logic                     ovf_reg;
  logic                     push_ready;

  logic signed [DW-1:0]     d_ch [NCH];
  logic signed [DW-1:0]     w_ch [NCH];
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W:0]    biased, shifted;
  logic signed [63:0]       wide, clamped;
  logic [DW-1:0]            act_value;
  logic                     act_ovf;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign d_ch[gi] = d_reg[gi*DW +: DW];
    assign w_ch[gi] = w_reg[gi*DW +: DW];
  end

  assign prod = d_ch[ch_reg] * w_ch[ch_reg];

  // Wrap mode keeps the low bits; every other mode clamps and flags any change.
  always_comb begin
    biased    = (ACC_W + 1)'(acc_reg) + (ACC_W + 1)'(bias_reg);
    shifted   = biased >>> shift_reg;
    wide      = 64'(shifted);
    clamped   = saturate(wide, DW, mode_reg == MODE_RELU);
    act_value = clamped[DW-1:0];
    act_ovf   = (clamped != wide);
    if (mode_reg == MODE_WRAP) begin
      act_value = shifted[DW-1:0];
      act_ovf   = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (START) state_next = ST_MAC;
      ST_MAC:   if (ch_reg == CH_LAST) state_next = ST_ACT;
      ST_ACT:   state_next = ST_WRITE;
      ST_WRITE: if (push_ready) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLKEXT or negedge RST_GLO) begin
    if (!RST_GLO)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge CLKEXT or negedge RST_GLO) begin
    if (!RST_GLO) begin
      d_reg      <= '0;
      w_reg      <= '0;
      bias_reg   <= '0;
      mode_reg   <= '0;
      shift_reg  <= '0;
      acc_reg    <= '0;
      ch_reg     <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && START) begin
        d_reg     <= D_IN;
        w_reg     <= W_IN;
        bias_reg  <= BIAS_IN;
        mode_reg  <= MODE;
        shift_reg <= SHIFT;
        acc_reg   <= '0;
        ch_reg    <= '0;
        ovf_reg   <= 1'b0;
      end
      if (state_reg == ST_MAC) begin
        acc_reg <= acc_reg + ACC_W'(prod);
        ch_reg  <= ch_reg + CH_W'(1);
      end
      if (state_reg == ST_ACT) begin
        result_reg <= act_value;
        if (act_ovf)
          ovf_reg <= 1'b1;
      end
    end
  end

  npu_out_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLKEXT),
    .rst_n      (RST_GLO),
    .push       (state_reg == ST_WRITE),
    .push_data  (result_reg),
    .rd_en      (RD_EN),
    .push_ready (push_ready),
    .d_out      (D_OUT),
    .d_valid    (D_VALID),
    .full       (FIFO_FULL),
    .empty      (FIFO_EMPTY),
    .count      (FIFO_COUNT)
  );

  assign BUSY        = (state_reg == ST_MAC) || (state_reg == ST_ACT) || (state_reg == ST_WRITE);
  assign DONE        = (state_reg == ST_DONE);
  assign OVF         = ovf_reg;
  assign STATE_DEBUG = state_reg;

endmodule
